// File: rtl/pipe_credit_rx.sv
// Credit-returning receive buffer at the far end of a fixed-latency pipeline.
// Beats land in a circular buffer; each pop returns one credit to the transmitter.
module pipe_credit_rx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_credit,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [$clog2(DEPTH):0]   o_max_level,
  output logic                     o_overflow,
  input  logic                     i_clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    max_level_r;
  logic             valid_r;
  logic             credit_r;
  logic             overflow_r;
  logic [WIDTH-1:0] data_r;

  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;
  logic             drop_s;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [LW-1:0]    level_nxt_s;
  logic [WIDTH-1:0] data_nxt_s;

  // Accept/drop decision, next level, and next head word (bypass when the write lands at the new head).
  always_comb begin
    pop_s   = valid_r & i_ready;
    full_s  = (level_r == LVL_FULL);
    wr_en_s = i_valid & (~full_s | pop_s);
    drop_s  = i_valid & full_s & ~pop_s;
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({wr_en_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
    if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      data_nxt_s = i_data;
    end else begin
      data_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Buffer storage and write pointer.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= i_data;
      wr_ptr_r        <= wr_ptr_r + PTR_ONE;
    end
  end

  // Read side: pointer, level, registered head word, valid and credit pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
      credit_r <= 1'b0;
      data_r   <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      valid_r  <= (level_nxt_s != '0);
      credit_r <= pop_s;
      data_r   <= data_nxt_s;
    end
  end

  // Status: high-water mark and sticky overflow (set wins over clear).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      max_level_r <= '0;
      overflow_r  <= 1'b0;
    end else begin
      if (level_nxt_s > max_level_r) begin
        max_level_r <= level_nxt_s;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (i_clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign o_valid     = valid_r;
  assign o_data      = data_r;
  assign o_credit    = credit_r;
  assign o_level     = level_r;
  assign o_max_level = max_level_r;
  assign o_overflow  = overflow_r;

endmodule

// File: tb/tb_pipe_credit_rx.sv
// Self-checking bench for pipe_credit_rx (DEPTH=4, WIDTH=8): vector table,
// directed corner sequences and a randomized run against a queue-based model.
module tb_pipe_credit_rx;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_ready = 1'b0;
  logic             i_clr_ovf = 1'b0;
  logic             o_credit;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_level;
  logic [2:0]       o_max_level;
  logic             o_overflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] q[$];
  int         m_max;
  logic       m_ovf;
  logic       m_credit;

  pipe_credit_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_data(i_data),
    .o_credit(o_credit), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_level(o_level), .o_max_level(o_max_level), .o_overflow(o_overflow),
    .i_clr_ovf(i_clr_ovf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       c;
    logic [2:0] lvl;
    logic       val;
    logic [7:0] dat;
    logic       cr;
    logic       ovf;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_max = 0;
    m_ovf = 1'b0;
    m_credit = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r, input logic c);
    bit popped;
    bit was_full;
    popped   = (q.size() != 0) && r;
    was_full = (q.size() == DEPTH);
    if (popped) void'(q.pop_front());
    if (v) begin
      if (!was_full || popped) q.push_back(d);
      else m_ovf = 1'b1;
    end else if (c) begin
      m_ovf = 1'b0;
    end
    if (v && was_full && !popped) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_credit = popped;
    if (q.size() > m_max) m_max = q.size();
  endtask

  task automatic model_compare(input string tag);
    chk({tag, ".level"}, 32'(o_level), 32'(q.size()));
    chk({tag, ".valid"}, 32'(o_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".data"}, 32'(o_data), 32'(q[0]));
    chk({tag, ".credit"}, 32'(o_credit), 32'(m_credit));
    chk({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
    chk({tag, ".max"}, 32'(o_max_level), 32'(m_max));
  endtask

  // drive one cycle, advance past the edge, update model, compare everything
  task automatic run_cycle(input string tag, input logic v, input logic [7:0] d, input logic r, input logic c);
    i_valid = v; i_data = d; i_ready = r; i_clr_ovf = c;
    @(posedge i_clk); #1;
    model_step(v, d, r, c);
    model_compare(tag);
  endtask

  task automatic do_reset();
    i_valid = 1'b0; i_ready = 1'b0; i_clr_ovf = 1'b0; i_data = '0;
    i_rstn = 1'b0;
    @(posedge i_clk); #1;
    model_clear();
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  initial begin
    int credits;
    int lvl_bad;
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 8'h11, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h22, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h33, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h41, 1'b0, 1'b0, 3'd1, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h42, 1'b0, 1'b0, 3'd2, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'h43, 1'b0, 1'b0, 3'd3, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h44, 1'b0, 1'b0, 3'd4, 1'b1, 8'h41, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h55, 1'b0, 1'b0, 3'd4, 1'b1, 8'h41, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 8'h66, 1'b1, 1'b0, 3'd4, 1'b1, 8'h42, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 8'h43, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h44, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h66, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0};

    // reset state
    #3;
    chk("rst.level", 32'(o_level), 32'd0);
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.data", 32'(o_data), 32'd0);
    chk("rst.credit", 32'(o_credit), 32'd0);
    chk("rst.ovf", 32'(o_overflow), 32'd0);
    chk("rst.max", 32'(o_max_level), 32'd0);
    do_reset();

    // vector table: fill/drain, overflow at full, push+pop at full
    credits = 0;
    for (int i = 0; i < 18; i++) begin
      i_valid = tbl[i].v; i_data = tbl[i].d; i_ready = tbl[i].r; i_clr_ovf = tbl[i].c;
      @(posedge i_clk); #1;
      chk($sformatf("tbl%0d.level", i), 32'(o_level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d.valid", i), 32'(o_valid), 32'(tbl[i].val));
      if (tbl[i].val) chk($sformatf("tbl%0d.data", i), 32'(o_data), 32'(tbl[i].dat));
      chk($sformatf("tbl%0d.credit", i), 32'(o_credit), 32'(tbl[i].cr));
      chk($sformatf("tbl%0d.ovf", i), 32'(o_overflow), 32'(tbl[i].ovf));
      if (i >= 7 && o_credit) credits++;
    end
    chk("tbl.max_level", 32'(o_max_level), 32'd4);
    chk("tbl.credits_after_ovf", 32'(credits), 32'd5);

    // continuous push+pop from empty, wrapping the pointers
    do_reset();
    credits = 0;
    lvl_bad = 0;
    for (int i = 0; i < 11; i++) begin
      run_cycle("stream", i < 10, 8'(8'hA0 + i), 1'b1, 1'b0);
      if (o_credit) credits++;
      if (o_level > 3'd1) lvl_bad++;
    end
    run_cycle("stream", 1'b0, 8'h00, 1'b0, 1'b0);
    if (o_credit) credits++;
    chk("stream.credits", 32'(credits), 32'd10);
    chk("stream.level_le1", 32'(lvl_bad), 32'd0);

    // overflow coinciding with clear: set wins
    for (int i = 0; i < 4; i++) run_cycle("ovfclr", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    run_cycle("ovfclr", 1'b1, 8'hCF, 1'b0, 1'b1);
    chk("ovfclr.set_wins", 32'(o_overflow), 32'd1);
    run_cycle("ovfclr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovfclr.cleared", 32'(o_overflow), 32'd0);

    // asynchronous reset mid-cycle with three entries buffered
    do_reset();
    for (int i = 0; i < 3; i++) run_cycle("arst", 1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    #2;
    i_rstn = 1'b0;
    i_valid = 1'b1; i_data = 8'hEE;
    #1;
    chk("arst.level", 32'(o_level), 32'd0);
    chk("arst.valid", 32'(o_valid), 32'd0);
    chk("arst.data", 32'(o_data), 32'd0);
    chk("arst.max", 32'(o_max_level), 32'd0);
    chk("arst.credit", 32'(o_credit), 32'd0);
    @(posedge i_clk); #1;
    chk("arst.held_level", 32'(o_level), 32'd0);
    chk("arst.held_credit", 32'(o_credit), 32'd0);
    model_clear();
    @(negedge i_clk);
    i_rstn = 1'b1;
    run_cycle("arst_post", 1'b1, 8'h77, 1'b0, 1'b0);
    chk("arst.first_beat", 32'(o_data), 32'h77);
    run_cycle("arst_post", 1'b0, 8'h00, 1'b1, 1'b0);

    // randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      run_cycle("rand", $urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
                $urandom_range(0, 99) < 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_credit_rx.md
PIPE_CREDIT_RX -- requirements
Module: pipe_credit_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 16: receive buffer entries; power of 2, minimum 2; equals the transmitter's initial credit count.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port i_rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_valid  input  1  data beat arriving from the far end of the fixed-latency pipeline; no backpressure.
REQ-006 SHALL have port i_data  input  WIDTH  payload qualified by i_valid.
REQ-007 SHALL have port o_credit  output  1  one-cycle pulse per freed entry, returned to the transmitter through a return pipeline.
REQ-008 SHALL have port o_valid  output  1  downstream beat available.
REQ-009 SHALL have port o_data  output  WIDTH  downstream payload.
REQ-010 SHALL have port i_ready  input  1  downstream accept.
REQ-011 SHALL have port o_level  output  $clog2(DEPTH)+1  current entry count.
REQ-012 SHALL have port o_max_level  output  $clog2(DEPTH)+1  high-water mark of o_level since reset.
REQ-013 SHALL have port o_overflow  output  1  sticky error: beat arrived with no free entry.
REQ-014 SHALL have port i_clr_ovf  input  1  synchronous clear of o_overflow.

Function
REQ-015 SHALL store beats in a DEPTH-entry circular buffer with write and read pointers that wrap from DEPTH-1 to 0.
REQ-016 SHALL define push = i_valid and pop = o_valid && i_ready.
REQ-017 SHALL write i_data on push when o_level < DEPTH, or when o_level == DEPTH and pop is asserted in the same cycle.
REQ-018 SHALL drop the beat and set o_overflow on the next edge when push occurs with o_level == DEPTH and no pop; o_level, pointers, and stored data are then unchanged.
REQ-019 SHALL update o_level on each edge: +1 on accepted push without pop, -1 on pop without push, unchanged on both or neither.
REQ-020 SHALL assert o_valid exactly when o_level != 0, so a push into an empty buffer gives o_valid high one cycle later (first-word-fall-through).
REQ-021 SHALL drive o_data from the entry at the read pointer and hold it stable while o_valid && !i_ready.
REQ-022 SHALL keep o_data stable but undefined-in-meaning when o_valid is low; the bench checks it only when o_valid is high.
REQ-023 SHALL register o_credit so it is high for exactly one cycle, on the cycle after each pop; back-to-back pops produce back-to-back pulses.
REQ-024 SHALL NOT generate a credit for a dropped (overflow) beat.
REQ-025 SHALL update o_max_level to o_level whenever o_level exceeds it; it never decreases except on reset.
REQ-026 SHALL clear o_overflow on an edge with i_clr_ovf high; if an overflow occurs in the same cycle, set takes priority.
REQ-027 SHALL accept push and pop simultaneously at any level; at o_level == 0, push with i_ready high does not pop, because o_valid is low.

Reset
REQ-028 SHALL, while i_rstn is low, immediately force pointers, o_level, o_max_level, o_valid, o_credit, and o_overflow to 0; o_data resets to 0.
REQ-029 SHALL discard buffered entries on reset without emitting credits; the transmitter and return pipeline are reset in the same domain and restart at DEPTH credits.
REQ-030 SHALL ignore i_valid while i_rstn is low and resume accepting beats on the first rising edge after release.

Verification (DEPTH=4, WIDTH=8)
REQ-031 SHALL pass this test: push 0x11,0x22,0x33 on consecutive cycles with i_ready=0 -> o_level=3, o_valid=1, o_data=0x11, o_credit never pulses.
REQ-032 SHALL pass this test: continue from REQ-031, assert i_ready for 3 cycles -> o_data 0x11,0x22,0x33 in order, three consecutive o_credit pulses each lagging its pop by 1 cycle, o_level=0, o_max_level=3.
REQ-033 SHALL pass this test: fill to 4, then push 0x55 with i_ready=0 -> o_overflow=1, o_level=4, drained sequence excludes 0x55, exactly 4 credits returned.
REQ-034 SHALL pass this test: at o_level=4, push 0x66 with pop the same cycle -> no overflow, o_level stays 4, 0x66 is the last beat drained.
REQ-035 SHALL pass this test: continuous push and pop for 10 cycles from empty (pointer wrap) -> data in order, o_level toggles 0/1 only, 10 credits.
REQ-036 SHALL pass this test: assert i_rstn=0 mid-cycle with o_level=3 -> all outputs 0 before the next edge, no credit pulse, and a push after release is delivered as the first beat.
